fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front-end for the single-cycle RISC-V core. It owns the fetch program counter and drives the instruction memory through a request/acknowledge handshake. Fetched instructions are buffered, with their PCs, in a small prefetch FIFO and handed to the control unit over a valid/ready interface. A redirect input (branch/jump target) flushes the buffer and restarts fetch at the new address.

## Interface
- WORDSIZE, 64: width of addresses/PC.
- INSTRUCTION_SIZE, 32: instruction width.
- FIFO_DEPTH, 4: prefetch entries; power of two, ≥2.
- RESET_ADDR, 0: PC loaded on reset; must be 4-byte aligned.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- im_req  out  1  fetch request to instruction memory.
- im_addr  out  WORDSIZE  address of requested instruction (= fetch PC).
- im_ack  in  1  memory returns im_instruction for im_addr this cycle.
- im_instruction  in  INSTRUCTION_SIZE  instruction data, valid when im_req && im_ack.
- instr_valid  out  1  FIFO head holds an instruction.
- instr_ready  in  1  consumer accepts head this cycle.
- instr  out  INSTRUCTION_SIZE  head instruction.
- instr_pc  out  WORDSIZE  PC of head instruction.
- redirect_en  in  1  restart fetch at redirect_addr.
- redirect_addr  in  WORDSIZE  new fetch target.
- fetch_fault  out  1  misaligned redirect seen; fetch halted.
- perf_fetched  out  32  accepted-instruction counter (see Configuration).
- perf_flushed  out  32  discarded-entry counter (see Configuration).

## Operation
- States: FETCH, FULL, FAULT. Reset enters FETCH, fetch_pc = RESET_ADDR, FIFO empty.
- FETCH: im_req = 1, im_addr = fetch_pc. On im_req && im_ack: push {im_instruction, fetch_pc}, fetch_pc += 4 (mod 2^WORDSIZE, wraps silently). Go to FULL when the push makes count = FIFO_DEPTH with no simultaneous pop.
- FULL: im_req = 0. On pop (instr_valid && instr_ready) return to FETCH.
- Pop: when instr_valid && instr_ready, head advances; instr/instr_pc show next entry.
- Simultaneous push and pop in FETCH: count unchanged, both take effect.
- Redirect (redirect_en = 1), highest priority, any state except FAULT:
  - FIFO cleared (count = 0); a same-cycle ack'd instruction is dropped, not pushed.
  - A same-cycle pop is a completed transfer for the consumer; entry is gone either way.
  - redirect_addr[1:0] == 0: fetch_pc = redirect_addr, state FETCH.
  - redirect_addr[1:0] != 0: state FAULT, fetch_fault = 1.
- FAULT: im_req = 0, instr_valid = 0, all inputs ignored; exit only by reset.
- im_addr holds fetch_pc whenever im_req = 0.

## Timing
- Reset values: im_req = 1 in the first post-reset cycle (FETCH, empty), im_addr = RESET_ADDR, instr_valid = 0, instr = 0, instr_pc = 0, fetch_fault = 0, perf counters = 0.
- Reset has priority over redirect and handshakes; reset mid-fetch discards FIFO and in-progress handshake.
- Latency: ack in cycle N -> instr_valid = 1 with that instruction in cycle N+1 (if FIFO was empty).
- Zero-wait memory (im_ack tied 1) with instr_ready = 1: one instruction per cycle sustained.
- Redirect in cycle N -> im_addr = redirect_addr, im_req = 1, instr_valid = 0 in cycle N+1.
- im_req, im_addr, instr_valid, instr, instr_pc, fetch_fault depend only on registered state (no input-to-output combinational path).
- im_addr may change only after an accepted request or a redirect.

## Configuration
- FETCH_PERF_COUNTERS_EN defined: perf_fetched increments on every push; perf_flushed adds the number of valid entries discarded by a redirect, plus 1 if an ack'd instruction was dropped that cycle. Both wrap at 2^32 and reset to 0.
- Not defined: counters not implemented, perf_fetched and perf_flushed tied to 0.

## Test plan
- Reset, im_ack = 1, instr_ready = 1: im_addr 0x0, 0x4, 0x8 on successive cycles; instr_pc 0x0 appears one cycle after first ack.
- instr_ready = 0, im_ack = 1: exactly 4 pushes, then im_req = 0 and state FULL; one pop -> im_req = 1 next cycle at 0x10.
- FIFO holds 3 entries, redirect to 0x100 with same-cycle ack: next cycle instr_valid = 0, im_addr = 0x100; with macro, perf_flushed = 4.
- Redirect to 0x102: fetch_fault = 1, im_req = 0, instr_valid = 0 held for 20 cycles despite im_ack/redirect; rst_n = 0 clears it.
- fetch_pc = 2^64 − 4 (via redirect): next accepted request at 0x0.
- rst_n low for one cycle while FIFO full: next cycle FIFO empty, im_addr = RESET_ADDR, counters 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, runs the imem req/ack handshake and
// buffers fetched instructions in a prefetch FIFO. Optional perf counters: FETCH_PERF_COUNTERS_EN.
module fetch_unit #(
    parameter int unsigned         WORDSIZE         = 64,
    parameter int unsigned         INSTRUCTION_SIZE = 32,
    parameter int unsigned         FIFO_DEPTH       = 4,
    parameter logic [WORDSIZE-1:0] RESET_ADDR       = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        im_req,
    output logic [WORDSIZE-1:0]         im_addr,
    input  logic                        im_ack,
    input  logic [INSTRUCTION_SIZE-1:0] im_instruction,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [INSTRUCTION_SIZE-1:0] instr,
    output logic [WORDSIZE-1:0]         instr_pc,
    input  logic                        redirect_en,
    input  logic [WORDSIZE-1:0]         redirect_addr,
    output logic                        fetch_fault,
    output logic [31:0]                 perf_fetched,
    output logic [31:0]                 perf_flushed
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_FETCH,
        S_FULL,
        S_FAULT
    } state_t;

    state_t                      state;
    logic [WORDSIZE-1:0]         fetch_pc;
    logic [INSTRUCTION_SIZE-1:0] mem_instr [FIFO_DEPTH];
    logic [WORDSIZE-1:0]         mem_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;
    logic [CNT_W-1:0]            count;
    logic                        push;
    logic                        pop;

    // FAULT leaves the FIFO empty, so neither handshake can fire there
    assign push = (state == S_FETCH) && im_ack;
    assign pop  = (count != '0) && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            fetch_pc <= RESET_ADDR;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (state != S_FAULT) begin
            if (redirect_en) begin
                // Flush wins over any same-cycle push/pop
                head  <= '0;
                tail  <= '0;
                count <= '0;
                if (redirect_addr[1:0] == 2'b00) begin
                    fetch_pc <= redirect_addr;
                    state    <= S_FETCH;
                end else begin
                    state <= S_FAULT;
                end
            end else begin
                if (push) begin
                    mem_instr[tail] <= im_instruction;
                    mem_pc[tail]    <= fetch_pc;
                    tail            <= tail + PTR_W'(1);
                    fetch_pc        <= fetch_pc + WORDSIZE'(4);
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
                if (push && !pop && (count == CNT_W'(FIFO_DEPTH - 1))) begin
                    state <= S_FULL;
                end else if ((state == S_FULL) && pop) begin
                    state <= S_FETCH;
                end
            end
        end
    end

    assign im_req      = (state == S_FETCH);
    assign im_addr     = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = mem_instr[head];
    assign instr_pc    = mem_pc[head];
    assign fetch_fault = (state == S_FAULT);

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetched_cnt;
    logic [31:0] flushed_cnt;

    // A popped entry counts as delivered, not flushed; a dropped ack counts as flushed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_cnt <= '0;
            flushed_cnt <= '0;
        end else if (state != S_FAULT) begin
            if (redirect_en) begin
                flushed_cnt <= flushed_cnt + 32'(count) - 32'(pop) + 32'(push);
            end else if (push) begin
                fetched_cnt <= fetched_cnt + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_cnt;
    assign perf_flushed = flushed_cnt;
`else
    assign perf_fetched = '0;
    assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        im_req;
    logic [63:0] im_addr;
    logic        im_ack;
    logic [31:0] im_instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        redirect_en;
    logic [63:0] redirect_addr;
    logic        fetch_fault;
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_ack        (im_ack),
        .im_instruction(im_instruction),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .fetch_fault   (fetch_fault),
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } entry_t;

    entry_t      m_q[$];
    logic [63:0] m_pc;
    bit          m_fault;
    logic [31:0] m_fetched;
    logic [31:0] m_flushed;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: apply one clock edge using the inputs currently driven
    task automatic model_edge();
        bit req, pop, ack;
        entry_t e;
        if (!rst_n) begin
            m_q.delete();
            m_pc      = 64'h0;
            m_fault   = 1'b0;
            m_fetched = 32'h0;
            m_flushed = 32'h0;
        end else if (!m_fault) begin
            req = (m_q.size() < DEPTH);
            pop = (m_q.size() > 0) && instr_ready;
            ack = req && im_ack;
            if (redirect_en) begin
                m_flushed = m_flushed + 32'(m_q.size()) - (pop ? 32'd1 : 32'd0) + (ack ? 32'd1 : 32'd0);
                m_q.delete();
                if (redirect_addr[1:0] != 2'b00) m_fault = 1'b1;
                else m_pc = redirect_addr;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (ack) begin
                    e.ins = im_instruction;
                    e.pc  = m_pc;
                    m_q.push_back(e);
                    m_pc      = m_pc + 64'd4;
                    m_fetched = m_fetched + 32'd1;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit exp_req;
        exp_req = !m_fault && (m_q.size() < DEPTH);
        check("im_req", 64'(im_req), 64'(exp_req));
        check("im_addr", im_addr, m_pc);
        check("instr_valid", 64'(instr_valid), 64'(m_q.size() > 0));
        check("fetch_fault", 64'(fetch_fault), 64'(m_fault));
        if (m_q.size() > 0) begin
            check("instr", 64'(instr), 64'(m_q[0].ins));
            check("instr_pc", instr_pc, m_q[0].pc);
        end
`ifdef FETCH_PERF_COUNTERS_EN
        check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        check("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`else
        check("perf_fetched", 64'(perf_fetched), 64'h0);
        check("perf_flushed", 64'(perf_flushed), 64'h0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        im_instruction = $urandom;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        im_ack      = 1'b0;
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        im_ack         = 1'b0;
        im_instruction = 32'h0;
        instr_ready    = 1'b0;
        redirect_en    = 1'b0;
        redirect_addr  = 64'h0;
        m_pc           = 64'h0;
        m_fault        = 1'b0;
        m_fetched      = 32'h0;
        m_flushed      = 32'h0;
        @(negedge clk);

        // Reset state and zero-wait streaming
        do_reset();
        check("rst_im_req", 64'(im_req), 64'h1);
        check("rst_im_addr", im_addr, 64'h0);
        check("rst_instr", 64'(instr), 64'h0);
        check("rst_instr_pc", instr_pc, 64'h0);
        im_ack = 1'b1;
        instr_ready = 1'b1;
        step();
        check("stream_addr1", im_addr, 64'h4);
        check("stream_pc0", instr_pc, 64'h0);
        step();
        check("stream_addr2", im_addr, 64'h8);
        check("stream_pc1", instr_pc, 64'h4);
        check("stream_valid", 64'(instr_valid), 64'h1);

        // Fill to FULL, then a single pop reopens fetch at 0x10
        do_reset();
        im_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("full_req", 64'(im_req), 64'h0);
        step();
        check("full_hold_addr", im_addr, 64'h10);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("refetch_req", 64'(im_req), 64'h1);
        check("refetch_addr", im_addr, 64'h10);

        // Redirect with 3 buffered entries and a same-cycle ack
        do_reset();
        im_ack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        redirect_en = 1'b1;
        redirect_addr = 64'h100;
        step();
        redirect_en = 1'b0;
        check("redir_valid", 64'(instr_valid), 64'h0);
        check("redir_addr", im_addr, 64'h100);
        check("redir_req", 64'(im_req), 64'h1);
`ifdef FETCH_PERF_COUNTERS_EN
        check("redir_flushed", 64'(perf_flushed), 64'd4);
`endif

        // Misaligned redirect faults until reset
        redirect_en = 1'b1;
        redirect_addr = 64'h102;
        step();
        check("fault_set", 64'(fetch_fault), 64'h1);
        for (int i = 0; i < 20; i++) begin
            im_ack = 1'($urandom);
            instr_ready = 1'($urandom);
            redirect_en = 1'($urandom);
            redirect_addr = {32'h0, $urandom} & 64'hFFFF_FFFC;
            step();
            check("fault_hold", 64'(fetch_fault), 64'h1);
            check("fault_req", 64'(im_req), 64'h0);
            check("fault_valid", 64'(instr_valid), 64'h0);
        end
        do_reset();
        check("fault_clear", 64'(fetch_fault), 64'h0);

        // PC wraps past 2^64 - 4
        redirect_en = 1'b1;
        redirect_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_en = 1'b0;
        check("wrap_top", im_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        im_ack = 1'b1;
        step();
        check("wrap_zero", im_addr, 64'h0);
        check("wrap_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset while full
        do_reset();
        im_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        do_reset();
        check("rfull_valid", 64'(instr_valid), 64'h0);
        check("rfull_addr", im_addr, 64'h0);
        check("rfull_fetched", 64'(perf_fetched), 64'h0);
        check("rfull_flushed", 64'(perf_flushed), 64'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] a;
            im_ack      = ($urandom_range(0, 9) < 7);
            instr_ready = ($urandom_range(0, 9) < 6);
            redirect_en = ($urandom_range(0, 19) == 0);
            a = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 | (a & 64'hC);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            redirect_addr = a;
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
